// File: rtl/spi_xfer_queue.sv
// spi_xfer_queue
//   Command/response queue sitting in front of spi_master. Transfer words
//   {norx, nbits, data} are buffered in a TX FIFO and issued to spi_master
//   one at a time. Each returned MISO word is captured into an RX FIFO for the
//   bus side unless the entry was marked norx.
//
// Ports
//   clk_in, nrst          clock shared with spi_master, async active-low reset
//   wr_*                  TX push side (wr_data, wr_nbits = bits-1, wr_norx)
//   rd_*                  RX pop side, rd_data is the show-ahead head
//   tx_level, rx_level    entries held in each FIFO (0..depth)
//   busy                  sequencer is not IDLE (doubles as the state monitor)
//   m_*                   request/ready interface to spi_master
//
// Handshakes: a word moves on a rising edge where valid && ready are both 1.
// valid never depends on ready. wr_ready is "TX not full", rd_valid is "RX not
// empty". Toward spi_master, m_request is a one-cycle pulse and m_mosi_data /
// m_nbits stay stable from that pulse until m_ready reports completion.
module spi_xfer_queue #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk_in,
  input  logic                  nrst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [31:0]           wr_data,
  input  logic [5:0]            wr_nbits,
  input  logic                  wr_norx,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [31:0]           rd_data,
  output logic [DEPTH_LOG2:0]   tx_level,
  output logic [DEPTH_LOG2:0]   rx_level,
  output logic                  busy,
  output logic                  m_request,
  output logic [31:0]           m_mosi_data,
  output logic [5:0]            m_nbits,
  input  logic [31:0]           m_miso_data,
  input  logic                  m_ready
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_ARM    = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [38:0]           tx_mem_q [DEPTH];   // {norx, nbits, data}
  logic [31:0]           rx_mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [DEPTH_LOG2-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [DEPTH_LOG2:0]   tx_level_q, tx_level_d, rx_level_q, rx_level_d;
  logic                  norx_q, norx_d;
  logic                  m_request_q, m_request_d;
  logic [31:0]           m_mosi_data_q, m_mosi_data_d;
  logic [5:0]            m_nbits_q, m_nbits_d;

  logic [38:0] tx_head;
  logic        tx_push, tx_pop, rx_push, rx_pop, launch;

  always_comb begin
    tx_head = tx_mem_q[tx_rd_ptr_q];
    tx_push = wr_valid && (tx_level_q != FULL_LVL);
    // RX room is reserved at launch time: RX can only shrink while the transfer
    // runs, so the completion push can never find it full.
    launch  = (state_q == S_IDLE) && (tx_level_q != '0) &&
              (tx_head[38] || (rx_level_q != FULL_LVL));
    tx_pop  = launch;
    rx_push = (state_q == S_WAIT) && m_ready && !norx_q && (rx_level_q != FULL_LVL);
    rx_pop  = rd_ready && (rx_level_q != '0);

    tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + 1'b1 : tx_wr_ptr_q;
    tx_rd_ptr_d = tx_pop  ? tx_rd_ptr_q + 1'b1 : tx_rd_ptr_q;
    rx_wr_ptr_d = rx_push ? rx_wr_ptr_q + 1'b1 : rx_wr_ptr_q;
    rx_rd_ptr_d = rx_pop  ? rx_rd_ptr_q + 1'b1 : rx_rd_ptr_q;

    tx_level_d = tx_level_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_level_d = tx_level_q + 1'b1;
      2'b01:   tx_level_d = tx_level_q - 1'b1;
      default: tx_level_d = tx_level_q;
    endcase

    rx_level_d = rx_level_q;
    case ({rx_push, rx_pop})
      2'b10:   rx_level_d = rx_level_q + 1'b1;
      2'b01:   rx_level_d = rx_level_q - 1'b1;
      default: rx_level_d = rx_level_q;
    endcase

    state_d       = state_q;
    m_request_d   = 1'b0;
    norx_d        = norx_q;
    m_mosi_data_d = m_mosi_data_q;
    m_nbits_d     = m_nbits_q;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d       = S_LAUNCH;
          m_request_d   = 1'b1;
          m_mosi_data_d = tx_head[31:0];
          m_nbits_d     = tx_head[37:32];
          norx_d        = tx_head[38];
        end
      end
      S_LAUNCH: state_d = S_ARM;
      // spi_master's ready is registered and may still read 1 from the previous
      // transfer here, so this cycle ignores it.
      S_ARM:    state_d = S_WAIT;
      S_WAIT:   if (m_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      state_q       <= S_IDLE;
      tx_wr_ptr_q   <= '0;
      tx_rd_ptr_q   <= '0;
      rx_wr_ptr_q   <= '0;
      rx_rd_ptr_q   <= '0;
      tx_level_q    <= '0;
      rx_level_q    <= '0;
      norx_q        <= 1'b0;
      m_request_q   <= 1'b0;
      m_mosi_data_q <= '0;
      m_nbits_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tx_mem_q[i] <= '0;
        rx_mem_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      tx_wr_ptr_q   <= tx_wr_ptr_d;
      tx_rd_ptr_q   <= tx_rd_ptr_d;
      rx_wr_ptr_q   <= rx_wr_ptr_d;
      rx_rd_ptr_q   <= rx_rd_ptr_d;
      tx_level_q    <= tx_level_d;
      rx_level_q    <= rx_level_d;
      norx_q        <= norx_d;
      m_request_q   <= m_request_d;
      m_mosi_data_q <= m_mosi_data_d;
      m_nbits_q     <= m_nbits_d;
      if (tx_push) tx_mem_q[tx_wr_ptr_q] <= {wr_norx, wr_nbits, wr_data};
      if (rx_push) rx_mem_q[rx_wr_ptr_q] <= m_miso_data;
    end
  end

  assign wr_ready    = (tx_level_q != FULL_LVL);
  assign rd_valid    = (rx_level_q != '0);
  assign rd_data     = rx_mem_q[rx_rd_ptr_q];
  assign tx_level    = tx_level_q;
  assign rx_level    = rx_level_q;
  assign busy        = (state_q != S_IDLE);
  assign m_request   = m_request_q;
  assign m_mosi_data = m_mosi_data_q;
  assign m_nbits     = m_nbits_q;

endmodule
